// File: rtl/core_rvfi_trace_pkg.sv
// core_rvfi_trace_pkg
// Shared types and constants for the RVFI trace buffer.
//   XLEN / ILEN     : register/PC and instruction widths carried by the trace
//   TRC_FLAG_*      : bit positions inside trace_entry_t.flags
//   trace_entry_t   : one buffered retirement as presented on the trace stream
package core_rvfi_trace_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam int TRC_FLAG_TRAP = 0;
    localparam int TRC_FLAG_INTR = 1;
    localparam int TRC_FLAG_LOST = 2;

    typedef struct packed {
        logic [63:0]      order;
        logic [ILEN-1:0]  insn;
        logic [XLEN-1:0]  pc_rdata;
        logic [XLEN-1:0]  pc_wdata;
        logic [4:0]       rd_addr;
        logic [XLEN-1:0]  rd_wdata;
        logic [2:0]       flags;
    } trace_entry_t;

endpackage

// File: rtl/core_rvfi_trace_buffer_if.sv
// core_rvfi_trace_buffer_if
// Bundles the RVFI retirement inputs and the valid/ready trace stream.
//   slave  : the trace buffer (consumes rvfi_*, trc_ready; drives trc_*)
//   master : the environment (core + trace sink)
interface core_rvfi_trace_buffer_if;
    import core_rvfi_trace_pkg::*;

    logic              rvfi_valid;
    logic [ILEN-1:0]   rvfi_insn;
    logic              rvfi_trap;
    logic              rvfi_intr;
    logic [XLEN-1:0]   rvfi_pc_rdata;
    logic [XLEN-1:0]   rvfi_pc_wdata;
    logic              rvfi_rd_wen;
    logic [4:0]        rvfi_rd_addr;
    logic [XLEN-1:0]   rvfi_rd_wdata;

    logic              trc_valid;
    logic              trc_ready;
    logic [63:0]       trc_order;
    logic [ILEN-1:0]   trc_insn;
    logic [XLEN-1:0]   trc_pc_rdata;
    logic [XLEN-1:0]   trc_pc_wdata;
    logic [4:0]        trc_rd_addr;
    logic [XLEN-1:0]   trc_rd_wdata;
    logic [2:0]        trc_flags;

    modport slave (
        input  rvfi_valid, rvfi_insn, rvfi_trap, rvfi_intr, rvfi_pc_rdata,
               rvfi_pc_wdata, rvfi_rd_wen, rvfi_rd_addr, rvfi_rd_wdata,
               trc_ready,
        output trc_valid, trc_order, trc_insn, trc_pc_rdata, trc_pc_wdata,
               trc_rd_addr, trc_rd_wdata, trc_flags
    );

    modport master (
        output rvfi_valid, rvfi_insn, rvfi_trap, rvfi_intr, rvfi_pc_rdata,
               rvfi_pc_wdata, rvfi_rd_wen, rvfi_rd_addr, rvfi_rd_wdata,
               trc_ready,
        input  trc_valid, trc_order, trc_insn, trc_pc_rdata, trc_pc_wdata,
               trc_rd_addr, trc_rd_wdata, trc_flags
    );

endinterface

// File: rtl/core_rvfi_trace_buffer_fifo.sv
// core_rvfi_trace_fifo
// Generic synchronous first-word-fall-through FIFO. The head entry is read
// straight out of registered storage, so rdata/empty depend only on state.
//   g_clk, g_resetn : clock, synchronous active-low reset (pointers/count)
//   push, wdata     : write; caller guarantees !full or a same-cycle pop
//   pop             : consume head; caller guarantees !empty
//   rdata           : head entry, valid while !empty
//   full/empty/count: occupancy, count in 0..DEPTH
module core_rvfi_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge g_clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

endmodule

// File: rtl/core_rvfi_trace_buffer.sv
// core_rvfi_trace_buffer
// Stamps each RVFI retirement (NRET=1) with a 64-bit order number, buffers it
// in a FWFT FIFO and drains it over a valid/ready trace stream.
//   g_clk, g_resetn : clock, synchronous active-low reset
//   bus (slave)     : rvfi_* retirement inputs, trc_* trace stream
//   drop_count      : saturating count of retirements lost to overflow
//   core_stall      : back-pressure to the core
// Build option CORE_RVFI_TRACE_STALL_EN: when defined, core_stall is raised
// (registered) once count >= DEPTH-1 so the core's one in-flight retirement
// always finds a slot; when undefined core_stall is 0 and overflow drops.
module core_rvfi_trace_buffer
    import core_rvfi_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      g_clk,
    input  logic                      g_resetn,
    core_rvfi_trace_buffer_if.slave   bus,
    output logic [15:0]               drop_count,
    output logic                      core_stall
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    trace_entry_t wr_entry;
    trace_entry_t rd_entry;
    logic         full, empty, push, pop, drop, rd_keep, lost_pending;
    logic [AW:0]  count;
    logic [63:0]  order;

    assign pop  = !empty & bus.trc_ready;
    assign push = bus.rvfi_valid & (!full | pop);
    assign drop = bus.rvfi_valid & full & !pop;

    // x0 writes are architecturally invisible, so they trace as "no write".
    assign rd_keep = bus.rvfi_rd_wen & (bus.rvfi_rd_addr != 5'd0);

    always_comb begin
        wr_entry                      = '0;
        wr_entry.order                = order;
        wr_entry.insn                 = bus.rvfi_insn;
        wr_entry.pc_rdata             = bus.rvfi_pc_rdata;
        wr_entry.pc_wdata             = bus.rvfi_pc_wdata;
        wr_entry.rd_addr              = rd_keep ? bus.rvfi_rd_addr  : 5'd0;
        wr_entry.rd_wdata             = rd_keep ? bus.rvfi_rd_wdata : '0;
        wr_entry.flags[TRC_FLAG_TRAP] = bus.rvfi_trap;
        wr_entry.flags[TRC_FLAG_INTR] = bus.rvfi_intr;
        wr_entry.flags[TRC_FLAG_LOST] = lost_pending;
    end

    core_rvfi_trace_fifo #(
        .WIDTH ($bits(trace_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .push     (push),
        .wdata    (wr_entry),
        .pop      (pop),
        .rdata    (rd_entry),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Order advances on every retirement, pushed or dropped, so a drop
    // shows up downstream as a gap in trc_order.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            order        <= '0;
            lost_pending <= 1'b0;
            drop_count   <= '0;
        end else begin
            if (bus.rvfi_valid) order <= order + 64'd1;
            if (drop)           lost_pending <= 1'b1;
            else if (push)      lost_pending <= 1'b0;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

`ifdef CORE_RVFI_TRACE_STALL_EN
    localparam logic [AW:0] CNT_STALL = (AW+1)'(DEPTH - 1);
    logic [AW:0] count_nxt;

    // Registered from next-state count so core_stall == (count >= DEPTH-1).
    assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_ff @(posedge g_clk) begin
        if (!g_resetn) core_stall <= 1'b0;
        else           core_stall <= (count_nxt >= CNT_STALL);
    end
`else
    assign core_stall = 1'b0;
`endif

    // Occupancy invariants of the FIFO as seen from this level.
    count_in_range: assert property (@(posedge g_clk) disable iff (!g_resetn)
        (count <= CNT_FULL) && (full == (count == CNT_FULL)));

    assign bus.trc_valid    = !empty;
    assign bus.trc_order    = rd_entry.order;
    assign bus.trc_insn     = rd_entry.insn;
    assign bus.trc_pc_rdata = rd_entry.pc_rdata;
    assign bus.trc_pc_wdata = rd_entry.pc_wdata;
    assign bus.trc_rd_addr  = rd_entry.rd_addr;
    assign bus.trc_rd_wdata = rd_entry.rd_wdata;
    assign bus.trc_flags    = rd_entry.flags;

endmodule

// File: tb/tb_core_rvfi_trace_buffer.sv
// tb_core_rvfi_trace_buffer
// Directed + randomized bench for core_rvfi_trace_buffer against a queue-based
// reference model. Build option CORE_RVFI_TRACE_STALL_EN selects the stall
// variant of the expectations.
module tb_core_rvfi_trace_buffer;
    import core_rvfi_trace_pkg::*;

    localparam int DEPTH = 8;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic [15:0] drop_count;
    logic        core_stall;

    core_rvfi_trace_buffer_if bus();

    core_rvfi_trace_buffer #(.DEPTH(DEPTH)) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .bus        (bus),
        .drop_count (drop_count),
        .core_stall (core_stall)
    );

    always #5 g_clk = ~g_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of expected entries plus order/lost/drop state.
    trace_entry_t mq[$];
    trace_entry_t m_e;
    logic [63:0]  m_order = '0;
    logic         m_lost = 1'b0;
    int           m_drops = 0;
    bit           m_pop, m_push;

    always @(posedge g_clk) begin
        if (!g_resetn) begin
            mq.delete();
            m_order = '0;
            m_lost  = 1'b0;
            m_drops = 0;
        end else begin
            m_pop  = (mq.size() != 0) && bus.trc_ready;
            m_push = 1'b0;
            if (bus.rvfi_valid) begin
                if (mq.size() == DEPTH && !m_pop) begin
                    m_lost = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end else begin
                    m_push = 1'b1;
                    m_e = '0;
                    m_e.order    = m_order;
                    m_e.insn     = bus.rvfi_insn;
                    m_e.pc_rdata = bus.rvfi_pc_rdata;
                    m_e.pc_wdata = bus.rvfi_pc_wdata;
                    if (bus.rvfi_rd_wen && bus.rvfi_rd_addr != 5'd0) begin
                        m_e.rd_addr  = bus.rvfi_rd_addr;
                        m_e.rd_wdata = bus.rvfi_rd_wdata;
                    end
                    m_e.flags = {m_lost, bus.rvfi_intr, bus.rvfi_trap};
                end
                m_order = m_order + 64'd1;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back(m_e);
                m_lost = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        logic exp_stall;
`ifdef CORE_RVFI_TRACE_STALL_EN
        exp_stall = (mq.size() >= DEPTH - 1);
`else
        exp_stall = 1'b0;
`endif
        check("m_valid", bus.trc_valid, (mq.size() != 0));
        check("m_drops", drop_count, m_drops);
        check("m_stall", core_stall, exp_stall);
        if (mq.size() != 0) begin
            check("m_order", bus.trc_order,    mq[0].order);
            check("m_insn",  bus.trc_insn,     mq[0].insn);
            check("m_pcr",   bus.trc_pc_rdata, mq[0].pc_rdata);
            check("m_pcw",   bus.trc_pc_wdata, mq[0].pc_wdata);
            check("m_rda",   bus.trc_rd_addr,  mq[0].rd_addr);
            check("m_rdd",   bus.trc_rd_wdata, mq[0].rd_wdata);
            check("m_flags", bus.trc_flags,    mq[0].flags);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
        model_check();
    endtask

    task automatic drive_idle();
        bus.rvfi_valid    = 1'b0;
        bus.rvfi_insn     = '0;
        bus.rvfi_trap     = 1'b0;
        bus.rvfi_intr     = 1'b0;
        bus.rvfi_pc_rdata = '0;
        bus.rvfi_pc_wdata = '0;
        bus.rvfi_rd_wen   = 1'b0;
        bus.rvfi_rd_addr  = '0;
        bus.rvfi_rd_wdata = '0;
    endtask

    task automatic drive_ret(input logic [63:0] pc, input logic wen,
                             input logic [4:0] a, input logic [63:0] d);
        bus.rvfi_valid    = 1'b1;
        bus.rvfi_insn     = $urandom;
        bus.rvfi_trap     = 1'b0;
        bus.rvfi_intr     = 1'b0;
        bus.rvfi_pc_rdata = pc;
        bus.rvfi_pc_wdata = pc + 64'd4;
        bus.rvfi_rd_wen   = wen;
        bus.rvfi_rd_addr  = a;
        bus.rvfi_rd_wdata = d;
    endtask

    task automatic do_reset();
        g_resetn = 1'b0;
        drive_idle();
        tick();
        tick();
        g_resetn = 1'b1;
    endtask

    initial begin
        logic stall_prev;
        int   rdy_pct;
        int   n;

        bus.trc_ready = 1'b0;
        drive_idle();

        // Reset state.
        do_reset();
        check("rst_valid", bus.trc_valid, 1'b0);
        check("rst_drop",  drop_count, 16'd0);
        check("rst_stall", core_stall, 1'b0);

        // Three back-to-back retirements, each visible one cycle later.
        bus.trc_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_ret(64'h1000 + 64'(4 * i), 1'b1, 5'(i + 1), {$urandom, $urandom});
            tick();
            check($sformatf("b2b_order%0d", i), bus.trc_order, 64'(i));
            check($sformatf("b2b_pc%0d", i), bus.trc_pc_rdata, 64'h1000 + 64'(4 * i));
            check($sformatf("b2b_flags%0d", i), bus.trc_flags, 3'b000);
        end
        drive_idle();
        tick();
        check("b2b_empty", bus.trc_valid, 1'b0);

        // rd masking: wen=0, and x0 writes.
        drive_ret(64'h2000, 1'b0, 5'd5, 64'hDEAD);
        tick();
        check("mask_wen_addr", bus.trc_rd_addr, 5'd0);
        check("mask_wen_data", bus.trc_rd_wdata, 64'd0);
        check("mask_order", bus.trc_order, 64'd3);
        drive_ret(64'h2004, 1'b1, 5'd0, 64'hBEEF);
        tick();
        check("mask_x0_data", bus.trc_rd_wdata, 64'd0);
        drive_idle();
        tick();

`ifndef CORE_RVFI_TRACE_STALL_EN
        // Overflow: 10 retirements into a stalled sink, two are dropped.
        do_reset();
        bus.trc_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_ret(64'h3000 + 64'(4 * i), 1'b1, 5'(i + 1), {$urandom, $urandom});
            tick();
        end
        drive_idle();
        tick();
        check("ovf_drops", drop_count, 16'd2);
        check("ovf_head",  bus.trc_order, 64'd0);

        // Full FIFO with simultaneous push and pop: no drop, lost flag set.
        bus.trc_ready = 1'b1;
        drive_ret(64'h4000, 1'b1, 5'd7, 64'h1234);
        tick();
        check("ovf_pp_drops", drop_count, 16'd2);
        drive_idle();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ovf_drain%0d", k), bus.trc_order, (k < 7) ? 64'(k + 1) : 64'd10);
            if (k == 7) check("ovf_lost", bus.trc_flags[TRC_FLAG_LOST], 1'b1);
            else        check($sformatf("ovf_nolost%0d", k), bus.trc_flags[TRC_FLAG_LOST], 1'b0);
            tick();
        end
        check("ovf_empty", bus.trc_valid, 1'b0);
`endif

        // Reset with entries queued.
        bus.trc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_ret(64'h5000 + 64'(4 * i), 1'b1, 5'd3, {$urandom, $urandom});
            tick();
        end
        check("q4_valid", bus.trc_valid, 1'b1);
        g_resetn = 1'b0;
        drive_idle();
        tick();
        check("q4_rst_valid", bus.trc_valid, 1'b0);
        check("q4_rst_drop",  drop_count, 16'd0);
        g_resetn = 1'b1;
        bus.trc_ready = 1'b1;
        drive_ret(64'h6000, 1'b1, 5'd4, 64'h55);
        tick();
        check("q4_first_order", bus.trc_order, 64'd0);
        drive_idle();
        tick();

`ifdef CORE_RVFI_TRACE_STALL_EN
        // Stall: core retires unless it saw core_stall the cycle before.
        do_reset();
        bus.trc_ready = 1'b0;
        stall_prev = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (!stall_prev) drive_ret(64'h7000 + 64'(4 * n), 1'b1, 5'd9, {$urandom, $urandom});
            else             drive_idle();
            stall_prev = core_stall;
            tick();
            if (bus.rvfi_valid) begin
                n++;
                if (n == 6) check("stall_at6", core_stall, 1'b0);
                if (n == 7) check("stall_at7", core_stall, 1'b1);
            end
        end
        drive_idle();
        check("stall_drops", drop_count, 16'd0);
        check("stall_n", 64'(n), 64'd8);
        bus.trc_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("stall_drain%0d", k), bus.trc_order, 64'(k));
            tick();
        end
        check("stall_empty", bus.trc_valid, 1'b0);
`endif

        // Randomized traffic with varying sink back-pressure.
        stall_prev = 1'b0;
        for (int c = 0; c < 600; c++) begin
            case (c / 150)
                0:       rdy_pct = 90;
                1:       rdy_pct = 30;
                2:       rdy_pct = 5;
                default: rdy_pct = 60;
            endcase
            bus.trc_ready     = ($urandom_range(0, 99) < rdy_pct);
            bus.rvfi_valid    = ($urandom_range(0, 9) < 7) && !stall_prev;
            bus.rvfi_insn     = $urandom;
            bus.rvfi_trap     = 1'($urandom);
            bus.rvfi_intr     = 1'($urandom);
            bus.rvfi_pc_rdata = {$urandom, $urandom};
            bus.rvfi_pc_wdata = {$urandom, $urandom};
            bus.rvfi_rd_wen   = 1'($urandom);
            bus.rvfi_rd_addr  = 5'($urandom);
            bus.rvfi_rd_wdata = {$urandom, $urandom};
`ifdef CORE_RVFI_TRACE_STALL_EN
            stall_prev = core_stall;
`endif
            tick();
        end
        drive_idle();
`ifdef CORE_RVFI_TRACE_STALL_EN
        check("rand_nodrop", drop_count, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
